mesh_out_port_wormhole_arb: RTL and testbench

- Per-output-port arbiter/sequencer for the mesh router crossbar.
- Shares one output link among dirs_p input directions (P, W, E, N, S) using round-robin selection.
- Holds the grant from a packet's first flit through its last flit (wormhole lock), so flits of different packets never interleave on a link.
- Zero-latency combinational forward path; grant pointer, lock state and statistics are sequential.

---
 rtl/mesh_out_port_wormhole_arb.sv | 128 ++++++++++++
 tb/tb_mesh_out_port_wormhole_arb.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mesh_out_port_wormhole_arb.sv
// Output-port arbiter for the mesh router: round-robin selection among input
// directions with wormhole locking from a packet's head flit through its tail.
module mesh_out_port_wormhole_arb #(
  parameter int dirs_p      = 5,
  parameter int width_p     = 8,
  parameter int cnt_width_p = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [dirs_p-1:0]           v_i,
  input  logic [dirs_p*width_p-1:0]   data_i,
  input  logic [dirs_p-1:0]           last_i,
  input  logic [dirs_p-1:0]           en_mask_i,
  output logic [dirs_p-1:0]           yumi_o,
  output logic                        v_o,
  output logic [width_p-1:0]          data_o,
  output logic                        last_o,
  input  logic                        ready_and_i,
  output logic [dirs_p-1:0]           grant_o,
  output logic                        locked_o,
  output logic [cnt_width_p-1:0]      pkt_cnt_o
);

  localparam int iw_lp = (dirs_p > 1) ? $clog2(dirs_p) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e                 state_r, state_n;
  logic [iw_lp-1:0]       rr_ptr_r, rr_ptr_n, lock_idx_r, lock_idx_n;
  logic [iw_lp-1:0]       win_idx_s, sel_idx_s, scan_idx_s;
  logic [cnt_width_p-1:0] pkt_cnt_r, pkt_cnt_n;
  logic [dirs_p-1:0]      cand_s, grant_s;
  logic [width_p-1:0]     data_s;
  logic                   found_s, locked_s, sel_v_s, v_s, last_s, hs_s;

  function automatic logic [iw_lp-1:0] wrap_inc(input logic [iw_lp-1:0] idx);
    return (idx == iw_lp'(dirs_p - 1)) ? '0 : idx + iw_lp'(1'b1);
  endfunction

  // Round-robin search: first candidate at or after rr_ptr, modulo dirs_p
  always_comb begin
    cand_s     = v_i & en_mask_i;
    found_s    = 1'b0;
    win_idx_s  = '0;
    scan_idx_s = '0;
    for (int k = 0; k < dirs_p; k++) begin
      scan_idx_s = iw_lp'((int'(rr_ptr_r) + k) % dirs_p);
      win_idx_s  = (!found_s && cand_s[scan_idx_s]) ? scan_idx_s : win_idx_s;
      found_s    = found_s | cand_s[scan_idx_s];
    end
  end

  assign locked_s  = (state_r == LOCKED);
  assign sel_idx_s = locked_s ? lock_idx_r : win_idx_s;
  assign sel_v_s   = locked_s | found_s;
  assign v_s       = locked_s ? v_i[lock_idx_r] : found_s;

  // One-hot grant and flit mux from the selected input
  always_comb begin
    grant_s = '0;
    data_s  = '0;
    last_s  = 1'b0;
    for (int d = 0; d < dirs_p; d++) begin
      grant_s[d] = sel_v_s && (sel_idx_s == iw_lp'(d));
      data_s     = grant_s[d] ? data_i[d*width_p +: width_p] : data_s;
      last_s     = grant_s[d] ? last_i[d] : last_s;
    end
  end

  // Reset masks every handshake-visible output so nothing is consumed that cycle
  assign grant_o   = reset ? '0 : grant_s;
  assign v_o       = v_s & ~reset;
  assign locked_o  = locked_s & ~reset;
  assign data_o    = data_s;
  assign last_o    = last_s;
  assign hs_s      = v_o & ready_and_i;
  assign yumi_o    = hs_s ? grant_o : '0;
  assign pkt_cnt_o = pkt_cnt_r;

  // Next-state: lock on a head flit, release and advance the pointer on a tail
  always_comb begin
    state_n    = state_r;
    rr_ptr_n   = rr_ptr_r;
    lock_idx_n = lock_idx_r;
    pkt_cnt_n  = pkt_cnt_r;
    case (state_r)
      IDLE: begin
        if (hs_s && last_s) begin
          rr_ptr_n  = wrap_inc(win_idx_s);
          pkt_cnt_n = pkt_cnt_r + cnt_width_p'(1'b1);
        end else if (hs_s) begin
          state_n    = LOCKED;
          lock_idx_n = win_idx_s;
        end else begin
          state_n = IDLE;
        end
      end
      LOCKED: begin
        if (hs_s && last_s) begin
          state_n   = IDLE;
          rr_ptr_n  = wrap_inc(lock_idx_r);
          pkt_cnt_n = pkt_cnt_r + cnt_width_p'(1'b1);
        end else begin
          state_n = LOCKED;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, pointer, lock owner and packet counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      rr_ptr_r   <= '0;
      lock_idx_r <= '0;
      pkt_cnt_r  <= '0;
    end else begin
      state_r    <= state_n;
      rr_ptr_r   <= rr_ptr_n;
      lock_idx_r <= lock_idx_n;
      pkt_cnt_r  <= pkt_cnt_n;
    end
  end

endmodule

// File: tb/tb_mesh_out_port_wormhole_arb.sv
// Bench for mesh_out_port_wormhole_arb: vector table, directed wormhole
// sequences and randomized traffic against a packet-level reference model.
module tb_mesh_out_port_wormhole_arb;
  localparam int N = 5;
  localparam int W = 8;
  localparam int C = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   v_i, last_i, en_mask_i, yumi_o, grant_o;
  logic [N*W-1:0] data_i;
  logic           v_o, last_o, ready_and_i, locked_o;
  logic [W-1:0]   data_o;
  logic [C-1:0]   pkt_cnt_o;

  mesh_out_port_wormhole_arb #(.dirs_p(N), .width_p(W), .cnt_width_p(C)) dut (
    .clk(clk), .reset(reset), .v_i(v_i), .data_i(data_i), .last_i(last_i),
    .en_mask_i(en_mask_i), .yumi_o(yumi_o), .v_o(v_o), .data_o(data_o),
    .last_o(last_o), .ready_and_i(ready_and_i), .grant_o(grant_o),
    .locked_o(locked_o), .pkt_cnt_o(pkt_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: who owns the link, where the round-robin turn sits, packets done
  bit m_locked;
  int m_owner, m_ptr, m_cnt;

  logic [N-1:0] s_grant, s_yumi;
  logic         s_v, s_locked, s_last;
  logic [W-1:0] s_data;
  logic [C-1:0] s_cnt;

  typedef struct packed {
    logic [N-1:0] v, last, en;
    logic         rdy, rst;
    logic [N-1:0] exp_grant;
    logic         exp_v, exp_locked;
    logic [C-1:0] exp_cnt;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [N*W-1:0] rnd_data();
    return (N*W)'({$urandom(), $urandom()});
  endfunction

  task automatic apply(input logic [N-1:0] v, input logic [N-1:0] l, input logic [N-1:0] en,
                       input logic rdy, input logic rst, input logic [N*W-1:0] d);
    int g;
    logic ev;
    logic [N-1:0] eg, ey, cand;
    reset = rst; v_i = v; last_i = l; en_mask_i = en; ready_and_i = rdy; data_i = d;
    @(negedge clk);
    cand = v & en;
    g = -1;
    ev = 1'b0;
    if (m_locked) begin
      g  = m_owner;
      ev = v[m_owner];
    end else begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (g < 0 && cand[idx]) g = idx;
      end
      ev = (g >= 0);
    end
    eg = (g >= 0 && !rst) ? (N'(1) << g) : '0;
    if (rst) ev = 1'b0;
    ey = (ev && rdy) ? eg : '0;
    s_grant = grant_o; s_yumi = yumi_o; s_v = v_o; s_locked = locked_o;
    s_last = last_o; s_data = data_o; s_cnt = pkt_cnt_o;
    chk("model_grant", 40'(grant_o), 40'(eg));
    chk("model_v", 40'(v_o), 40'(ev));
    chk("model_yumi", 40'(yumi_o), 40'(ey));
    chk("model_locked", 40'(locked_o), 40'(m_locked && !rst));
    chk("model_cnt", 40'(pkt_cnt_o), 40'(m_cnt));
    if (ev) begin
      chk("model_data", 40'(data_o), 40'(d[g*W +: W]));
      chk("model_last", 40'(last_o), 40'(l[g]));
    end
    @(posedge clk);
    if (rst) begin
      m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    end else if (ev && rdy) begin
      if (!m_locked && l[g]) begin
        m_ptr = (g + 1) % N; m_cnt = (m_cnt + 1) % (1 << C);
      end else if (!m_locked) begin
        m_locked = 1'b1; m_owner = g;
      end else if (l[g]) begin
        m_locked = 1'b0; m_ptr = (m_owner + 1) % N; m_cnt = (m_cnt + 1) % (1 << C);
      end
    end
    #1;
  endtask

  function automatic vec_t mk(input logic [N-1:0] v, input logic [N-1:0] en, input logic rst,
                              input logic [N-1:0] eg, input logic ev, input logic [C-1:0] ec);
    vec_t t;
    t.v = v; t.last = 5'h1f; t.en = en; t.rdy = 1'b1; t.rst = rst;
    t.exp_grant = eg; t.exp_v = ev; t.exp_locked = 1'b0; t.exp_cnt = ec;
    return t;
  endfunction

  initial begin
    logic [N*W-1:0] dd;
    logic [N-1:0]   rv, rl, ren;

    tbl[0] = mk(5'h1f, 5'h1f, 1'b1, 5'h00, 1'b0, 8'd0);
    for (int i = 1; i <= 10; i++)
      tbl[i] = mk(5'h1f, 5'h1f, 1'b0, 5'h01 << ((i - 1) % 5), 1'b1, C'(i - 1));
    tbl[11] = mk(5'h1f, 5'h05, 1'b0, 5'h01, 1'b1, 8'd10);
    tbl[12] = mk(5'h1f, 5'h05, 1'b0, 5'h04, 1'b1, 8'd11);
    tbl[13] = mk(5'h1f, 5'h05, 1'b0, 5'h01, 1'b1, 8'd12);
    tbl[14] = mk(5'h1f, 5'h05, 1'b0, 5'h04, 1'b1, 8'd13);
    tbl[15] = mk(5'h1f, 5'h00, 1'b0, 5'h00, 1'b0, 8'd14);
    tbl[16] = mk(5'h00, 5'h1f, 1'b0, 5'h00, 1'b0, 8'd14);

    reset = 1'b1; v_i = '0; last_i = '0; en_mask_i = '0; ready_and_i = 1'b0; data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].v, tbl[i].last, tbl[i].en, tbl[i].rdy, tbl[i].rst, rnd_data());
      chk("tbl_grant", 40'(s_grant), 40'(tbl[i].exp_grant));
      chk("tbl_v", 40'(s_v), 40'(tbl[i].exp_v));
      chk("tbl_locked", 40'(s_locked), 40'(tbl[i].exp_locked));
      chk("tbl_cnt", 40'(s_cnt), 40'(tbl[i].exp_cnt));
    end

    // three-flit packet on input 2 while 0 and 4 also request
    apply(5'h02, 5'h1f, 5'h1f, 1'b1, 1'b0, rnd_data());
    for (int f = 0; f < 3; f++) begin
      apply(5'h15, (f == 2) ? 5'h1f : 5'h1b, 5'h1f, 1'b1, 1'b0, rnd_data());
      chk("worm_grant", 40'(s_grant), 40'h04);
      chk("worm_yumi", 40'(s_yumi), 40'h04);
      chk("worm_locked", 40'(s_locked), 40'(f != 0));
    end
    apply(5'h15, 5'h1f, 5'h1f, 1'b1, 1'b0, rnd_data());
    chk("worm_next_grant", 40'(s_grant), 40'h10);
    chk("worm_cnt", 40'(s_cnt), 40'd16);

    // bubble inside a packet locked on input 1
    apply(5'h02, 5'h1d, 5'h1f, 1'b1, 1'b0, rnd_data());
    repeat (2) begin
      apply(5'h1d, 5'h1f, 5'h1f, 1'b1, 1'b0, rnd_data());
      chk("bubble_v", 40'(s_v), 40'h0);
      chk("bubble_yumi", 40'(s_yumi), 40'h0);
      chk("bubble_grant", 40'(s_grant), 40'h02);
    end
    dd = rnd_data();
    apply(5'h1f, 5'h1f, 5'h1f, 1'b1, 1'b0, dd);
    chk("bubble_resume_yumi", 40'(s_yumi), 40'h02);
    chk("bubble_resume_data", 40'(s_data), 40'(dd[15:8]));

    // downstream stall on input 3
    dd = rnd_data();
    repeat (4) begin
      apply(5'h08, 5'h1f, 5'h1f, 1'b0, 1'b0, dd);
      chk("stall_v", 40'(s_v), 40'h1);
      chk("stall_yumi", 40'(s_yumi), 40'h0);
      chk("stall_data", 40'(s_data), 40'(dd[31:24]));
      chk("stall_cnt", 40'(s_cnt), 40'd18);
    end
    apply(5'h08, 5'h1f, 5'h1f, 1'b1, 1'b0, dd);
    chk("stall_release_yumi", 40'(s_yumi), 40'h08);

    // mask cleared mid-packet on input 0 does not break the packet
    apply(5'h1f, 5'h1f, 5'h1f, 1'b1, 1'b1, rnd_data());
    apply(5'h1f, 5'h1e, 5'h05, 1'b1, 1'b0, rnd_data());
    chk("mask_head_grant", 40'(s_grant), 40'h01);
    apply(5'h1f, 5'h1f, 5'h04, 1'b1, 1'b0, rnd_data());
    chk("mask_tail_yumi", 40'(s_yumi), 40'h01);
    chk("mask_tail_locked", 40'(s_locked), 40'h1);
    apply(5'h1f, 5'h1f, 5'h04, 1'b1, 1'b0, rnd_data());
    chk("mask_after_grant", 40'(s_grant), 40'h04);

    // reset during the second flit of a four-flit packet
    apply(5'h00, 5'h00, 5'h1f, 1'b1, 1'b1, rnd_data());
    apply(5'h01, 5'h00, 5'h1f, 1'b1, 1'b0, rnd_data());
    apply(5'h01, 5'h00, 5'h1f, 1'b1, 1'b1, rnd_data());
    chk("rst_mid_grant", 40'(s_grant), 40'h0);
    chk("rst_mid_yumi", 40'(s_yumi), 40'h0);
    apply(5'h00, 5'h00, 5'h1f, 1'b1, 1'b0, rnd_data());
    chk("rst_after_locked", 40'(s_locked), 40'h0);
    chk("rst_after_cnt", 40'(s_cnt), 40'h0);
    apply(5'h1f, 5'h1f, 5'h1f, 1'b1, 1'b0, rnd_data());
    chk("rst_after_ptr_grant", 40'(s_grant), 40'h01);

    // packet counter wraps without saturating
    apply(5'h00, 5'h1f, 5'h1f, 1'b1, 1'b1, rnd_data());
    repeat (256) apply(5'h1f, 5'h1f, 5'h1f, 1'b1, 1'b0, rnd_data());
    apply(5'h00, 5'h1f, 5'h1f, 1'b1, 1'b0, rnd_data());
    chk("cnt_wrap", 40'(s_cnt), 40'h0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rv  = N'($urandom());
      rl  = ($urandom_range(0, 2) == 0) ? 5'h1f : N'($urandom());
      ren = ($urandom_range(0, 3) == 0) ? N'($urandom()) : 5'h1f;
      apply(rv, rl, ren, $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0, rnd_data());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
